// File: rtl/store_instruction_type.sv
//------------------------------------------------------------------------------
// Module      : store_instruction_type
// Description : MEM-stage store-data formatter; masks register data to the
//               store width and registers it with byte-lane enables.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module store_instruction_type #(
  parameter int DATA_W = 32,
  parameter int TYPE_W = 3
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [TYPE_W-1:0]   is_load_store_type,
  input  logic [DATA_W-1:0]   i_data_to_mem,
  output logic [DATA_W-1:0]   o_store,
  output logic [DATA_W/8-1:0] o_byte_en,
  output logic                o_valid
);

  localparam int                BE_W   = DATA_W / 8;
  localparam logic [TYPE_W-1:0] C_SB   = TYPE_W'(0);
  localparam logic [TYPE_W-1:0] C_SH   = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] C_SW   = TYPE_W'(3);

  logic [DATA_W-1:0] w_store;
  logic [BE_W-1:0]   w_byte_en;
  logic [DATA_W-1:0] r_store;
  logic [BE_W-1:0]   r_byte_en;
  logic              r_valid;

  // Unsupported codes yield no data and no lanes so memory is left untouched.
  always_comb begin
    w_store   = '0;
    w_byte_en = '0;
    case (is_load_store_type)
      C_SB: begin
        w_store[7:0] = i_data_to_mem[7:0];
        w_byte_en    = BE_W'(4'b0001);
      end
      C_SH: begin
        w_store[15:0] = i_data_to_mem[15:0];
        w_byte_en     = BE_W'(4'b0011);
      end
      C_SW: begin
        w_store   = i_data_to_mem;
        w_byte_en = '1;
      end
      default: begin
        w_store   = '0;
        w_byte_en = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_store   <= '0;
      r_byte_en <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_store   <= w_store;
        r_byte_en <= w_byte_en;
      end
    end
  end

  assign o_store   = r_store;
  assign o_byte_en = r_byte_en;
  assign o_valid   = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_store_instruction_type.sv
//------------------------------------------------------------------------------
// Module      : tb_store_instruction_type
// Description : Self-checking bench for store_instruction_type with a
//               behavioural reference model and randomized traffic.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_store_instruction_type;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [2:0]  ls_type;
  logic [31:0] data;
  logic [31:0] o_store;
  logic [3:0]  o_byte_en;
  logic        o_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference state: what the outputs should show after the last edge.
  logic [31:0] exp_store = '0;
  logic [3:0]  exp_be    = '0;
  logic        exp_valid = 1'b0;

  store_instruction_type dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_valid            (valid),
    .is_load_store_type (ls_type),
    .i_data_to_mem      (data),
    .o_store            (o_store),
    .o_byte_en          (o_byte_en),
    .o_valid            (o_valid)
  );

  always #5 clk = ~clk;

  // Store width in bytes per type code; 0 means unsupported.
  function automatic int width_bytes(input logic [2:0] t);
    case (t)
      3'd0:    return 1;
      3'd1:    return 2;
      3'd3:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic void model_edge(input logic r, input logic v,
                                     input logic [2:0] t, input logic [31:0] d);
    int n;
    longint unsigned modulus;
    if (r) begin
      exp_store = '0; exp_be = '0; exp_valid = 1'b0;
    end else begin
      exp_valid = v;
      if (v) begin
        n         = width_bytes(t);
        modulus   = 64'd1 << (8 * n);
        exp_store = 32'(longint'(d) % modulus);
        exp_be    = 4'((1 << n) - 1);
      end
    end
  endfunction

  // Apply one cycle of inputs, advance the model and step past the edge.
  task automatic apply(input logic r, input logic v, input logic [2:0] t,
                       input logic [31:0] d);
    @(negedge clk);
    reset = r; valid = v; ls_type = t; data = d;
    @(posedge clk);
    model_edge(r, v, t, d);
    #1;
  endtask

  task automatic test_reset;
    apply(1'b1, 1'b1, 3'd3, 32'hDEADBEEF);
    apply(1'b1, 1'b0, 3'd0, 32'h12345678);
    total_cnt++;
    if ({o_valid, o_byte_en, o_store} !== {1'b0, 4'b0000, 32'h0})
      $display("FAIL reset: got v=%b be=%b st=%h, want v=0 be=0000 st=00000000",
               o_valid, o_byte_en, o_store);
    else pass_cnt++;
  endtask

  task automatic test_directed;
    logic [2:0]  t_tab [4] = '{3'b000, 3'b001, 3'b011, 3'b110};
    logic [31:0] d_tab [4] = '{32'h00000F81, 32'h000F8001, 32'h04000001, 32'h00300230};
    logic [31:0] s_tab [4] = '{32'h00000081, 32'h00008001, 32'h04000001, 32'h00000000};
    logic [3:0]  b_tab [4] = '{4'b0001, 4'b0011, 4'b1111, 4'b0000};
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, t_tab[i], d_tab[i]);
      total_cnt++;
      if ({o_valid, o_byte_en, o_store} !== {1'b1, b_tab[i], s_tab[i]})
        $display("FAIL directed[%0d] type=%b: got v=%b be=%b st=%h, want v=1 be=%b st=%h",
                 i, t_tab[i], o_valid, o_byte_en, o_store, b_tab[i], s_tab[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_sweep;
    for (int t = 0; t < 8; t++) begin
      apply(1'b0, 1'b1, 3'(t), 32'hFFFFFFFF);
      total_cnt++;
      if ({o_valid, o_byte_en, o_store} !== {exp_valid, exp_be, exp_store})
        $display("FAIL sweep type=%0d: got v=%b be=%b st=%h, want v=%b be=%b st=%h",
                 t, o_valid, o_byte_en, o_store, exp_valid, exp_be, exp_store);
      else pass_cnt++;
    end
  endtask

  task automatic test_hold_reset;
    apply(1'b0, 1'b1, 3'b011, 32'h04000001);
    apply(1'b0, 1'b0, 3'b000, 32'hAAAAAAAA);
    total_cnt++;
    if ({o_valid, o_byte_en, o_store} !== {1'b0, 4'b1111, 32'h04000001})
      $display("FAIL hold: got v=%b be=%b st=%h, want v=0 be=1111 st=04000001",
               o_valid, o_byte_en, o_store);
    else pass_cnt++;
    apply(1'b1, 1'b1, 3'b011, 32'h55555555);
    total_cnt++;
    if ({o_valid, o_byte_en, o_store} !== {1'b0, 4'b0000, 32'h0})
      $display("FAIL reset_mid: got v=%b be=%b st=%h, want v=0 be=0000 st=00000000",
               o_valid, o_byte_en, o_store);
    else pass_cnt++;
    apply(1'b0, 1'b1, 3'b001, 32'hFFFF8765);
    total_cnt++;
    if ({o_valid, o_byte_en, o_store} !== {1'b1, 4'b0011, 32'h00008765})
      $display("FAIL after_reset: got v=%b be=%b st=%h, want v=1 be=0011 st=00008765",
               o_valid, o_byte_en, o_store);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic r, v;
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 15) == 0);
      v = $urandom_range(0, 3) != 0;
      apply(r, v, 3'($urandom_range(0, 7)), $urandom);
      total_cnt++;
      if ({o_valid, o_byte_en, o_store} !== {exp_valid, exp_be, exp_store})
        $display("FAIL random[%0d]: got v=%b be=%b st=%h, want v=%b be=%b st=%h",
                 i, o_valid, o_byte_en, o_store, exp_valid, exp_be, exp_store);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; ls_type = '0; data = '0;
    test_reset;
    test_directed;
    test_sweep;
    test_hold_reset;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

`default_nettype wire
